// File: rtl/sprite_copy_engine.sv
// Sprite blitter: copies a sprite_w x sprite_h block from on-chip memory to frame-buffer
// write strobes, one pixel per cycle, clipped to the screen. Optional macro SPRITE_TRANSPARENCY_EN.
module sprite_copy_engine #(
  parameter int          SCREEN_W          = 640,
  parameter int          SCREEN_H          = 480,
  parameter logic [15:0] TRANSPARENT_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute,
  output logic        done,
  input  logic [17:0] src_base,
  input  logic [9:0]  sprite_w,
  input  logic [9:0]  sprite_h,
  input  logic [9:0]  dest_x,
  input  logic [9:0]  dest_y,
  output logic [17:0] src_addr,
  input  logic [15:0] src_data,
  output logic [9:0]  program_x,
  output logic [9:0]  program_y,
  output logic [15:0] program_data,
  output logic        program_write
);

  localparam logic [10:0] LP_SCREEN_W = 11'(SCREEN_W);
  localparam logic [10:0] LP_SCREEN_H = 11'(SCREEN_H);
`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic LP_TRANS_EN = 1'b1;
`else
  localparam logic LP_TRANS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_w, r_h, r_dx, r_dy;
  logic [9:0]  r_col, r_row;
  logic [17:0] r_src_addr;
  logic        r_vld_p1;
  logic [10:0] r_px_p1, r_py_p1;
  logic        w_zero, w_start, w_last, w_in_frame, w_key_hit;

  assign w_zero  = (sprite_w == 10'd0) || (sprite_h == 10'd0);
  assign w_start = (r_state == S_IDLE) && execute && !w_zero;
  assign w_last  = (r_col == r_w - 10'd1) && (r_row == r_h - 10'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (execute) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (!execute) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == S_DONE);
  end

  // p0: address issue; src_addr steps by one since row*w+col is just the raster index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w        <= '0;
      r_h        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_src_addr <= '0;
    end else if (w_start) begin
      r_w        <= sprite_w;
      r_h        <= sprite_h;
      r_dx       <= dest_x;
      r_dy       <= dest_y;
      r_col      <= '0;
      r_row      <= '0;
      r_src_addr <= src_base;
    end else if (r_state == S_RUN) begin
      if (w_last) begin
        r_col <= '0;
        r_row <= '0;
      end else begin
        r_src_addr <= r_src_addr + 18'd1;
        if (r_col == r_w - 10'd1) begin
          r_col <= '0;
          r_row <= r_row + 10'd1;
        end else begin
          r_col <= r_col + 10'd1;
        end
      end
    end
  end

  // p1: coordinates line up with src_data returned for the previous address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_px_p1  <= '0;
      r_py_p1  <= '0;
    end else begin
      r_vld_p1 <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        r_px_p1 <= {1'b0, r_dx} + {1'b0, r_col};
        r_py_p1 <= {1'b0, r_dy} + {1'b0, r_row};
      end
    end
  end

  assign w_in_frame = (r_px_p1 < LP_SCREEN_W) && (r_py_p1 < LP_SCREEN_H);
  assign w_key_hit  = LP_TRANS_EN && (src_data == TRANSPARENT_COLOR);

  assign src_addr      = r_src_addr;
  assign program_x     = r_px_p1[9:0];
  assign program_y     = r_py_p1[9:0];
  assign program_data  = r_vld_p1 ? src_data : 16'h0000;
  assign program_write = r_vld_p1 && w_in_frame && !w_key_hit;

endmodule

// File: tb/tb_sprite_copy_engine.sv
// Bench for sprite_copy_engine: random memory image, raster-scan reference model, write scoreboard.
module tb_sprite_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        execute;
  logic        done;
  logic [17:0] src_base;
  logic [9:0]  sprite_w, sprite_h, dest_x, dest_y;
  logic [17:0] src_addr;
  logic [15:0] src_data;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;
  logic        program_write;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] d;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  logic [15:0] mem [0:262143];

  sprite_copy_engine dut (
    .clk(clk), .reset(reset), .execute(execute), .done(done),
    .src_base(src_base), .sprite_w(sprite_w), .sprite_h(sprite_h),
    .dest_x(dest_x), .dest_y(dest_y), .src_addr(src_addr), .src_data(src_data),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_data <= mem[src_addr];

  always @(negedge clk) begin
    if (program_write === 1'b1) begin
      wr_t w;
      w.x = int'(program_x);
      w.y = int'(program_y);
      w.d = program_data;
      obs.push_back(w);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_expected(input logic [17:0] base, input int w, input int h,
                                input int dx, input int dy);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        wr_t e;
        logic [17:0] a;
        bit keep;
        a = base + 18'(r * w + c);
        e.x = dx + c;
        e.y = dy + r;
        e.d = mem[a];
        keep = (e.x < 640) && (e.y < 480);
`ifdef SPRITE_TRANSPARENCY_EN
        if (e.d == 16'h0000) keep = 0;
`endif
        if (keep) exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_copy(input string name, input logic [17:0] base, input int w, input int h,
                          input int dx, input int dy, input int hold);
    int n;
    int exp_cyc;
    int nmin;
    exp_cyc = (w == 0 || h == 0) ? 1 : w * h + 2;
    build_expected(base, w, h, dx, dy);
    obs.delete();
    src_base = base;
    sprite_w = 10'(w);
    sprite_h = 10'(h);
    dest_x   = 10'(dx);
    dest_y   = 10'(dy);
    execute  = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        src_base = 18'($urandom);
        sprite_w = 10'($urandom);
        sprite_h = 10'($urandom);
        dest_x   = 10'($urandom);
        dest_y   = 10'($urandom);
      end
      if (done === 1'b1) break;
    end
    checks++;
    if (done !== 1'b1 || n != exp_cyc) begin
      failures++;
      $display("FAIL %s latency: done=%b after %0d cycles, required 1 after %0d", name, done, n, exp_cyc);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || obs.size() != exp_q.size()) begin
        failures++;
        $display("FAIL %s hold: done=%b writes=%0d, required done=1 writes=%0d", name, done, obs.size(), exp_q.size());
      end
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d, required %0d", name, obs.size(), exp_q.size());
    end
    nmin = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y || obs[i].d !== exp_q[i].d) begin
        failures++;
        $display("FAIL %s write%0d: got (%0d,%0d,%h), required (%0d,%0d,%h)", name, i,
                 obs[i].x, obs[i].y, obs[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d);
      end
    end
    execute = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_release: got %b, required 0", name, done);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (done !== 1'b0 || program_write !== 1'b0 || src_addr !== 18'd0 ||
        program_x !== 10'd0 || program_y !== 10'd0 || program_data !== 16'd0) begin
      failures++;
      $display("FAIL %s: got done=%b wr=%b addr=%h x=%0d y=%0d data=%h, required all zero",
               name, done, program_write, src_addr, program_x, program_y, program_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_zero_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 8; i++) mem[18'h100 + 18'(i)] = 16'hA000 + 16'(i);
    run_copy("ramp", 18'h100, 4, 2, 10, 20, 0);
  endtask

  task automatic test_zero_size();
    run_copy("zero_w", 18'h200, 0, 5, 3, 3, 0);
    run_copy("zero_h", 18'h200, 7, 0, 3, 3, 0);
  endtask

  task automatic test_clip();
    for (int i = 0; i < 9; i++) mem[18'h300 + 18'(i)] = 16'h1234 + 16'(i);
    run_copy("clip", 18'h300, 3, 3, 638, 478, 0);
    checks++;
    if (exp_q.size() != 4 || obs.size() != 4) begin
      failures++;
      $display("FAIL clip_count: got %0d writes, required 4", obs.size());
    end
  endtask

  task automatic test_transparency();
    mem[18'h400] = 16'h0000;
    mem[18'h401] = 16'hF800;
    run_copy("transparency", 18'h400, 2, 1, 100, 50, 0);
  endtask

  task automatic test_hold();
    run_copy("hold", 18'h500, 3, 2, 5, 6, 10);
  endtask

  task automatic test_reset_mid_copy();
    int base_cnt;
    src_base = 18'h1000;
    sprite_w = 10'd16;
    sprite_h = 10'd16;
    dest_x   = 10'd40;
    dest_y   = 10'd40;
    execute  = 1'b1;
    repeat (40) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero_outputs("reset_mid_run");
    execute = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    base_cnt = obs.size();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs.size() != base_cnt || done !== 1'b0 || src_addr !== 18'd0) begin
      failures++;
      $display("FAIL reset_no_resume: got %0d extra writes done=%b addr=%h, required 0 writes done=0 addr=0",
               obs.size() - base_cnt, done, src_addr);
    end
    run_copy("after_reset", 18'h1000, 16, 16, 40, 40, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [17:0] base;
      int w, h, dx, dy;
      base = ($urandom_range(0, 1) == 0) ? 18'($urandom) : 18'h3FFF0 + 18'($urandom_range(0, 15));
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 8);
      dx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(630, 639);
      dy = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(470, 479);
      run_copy($sformatf("random%0d", k), base, w, h, dx, dy, $urandom_range(0, 2));
    end
  endtask

  initial begin
    execute  = 1'b0;
    src_base = '0;
    sprite_w = '0;
    sprite_h = '0;
    dest_x   = '0;
    dest_y   = '0;
    for (int i = 0; i < 262144; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
    test_reset();
    test_ramp();
    test_zero_size();
    test_clip();
    test_transparency();
    test_hold();
    test_reset_mid_copy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
